// File: rtl/instr_encoder.sv
// Packs operand/opcode field sets into 32-bit instruction words and streams them
// into instruction memory at consecutive addresses starting from a captured base.
module instr_encoder #(
  parameter int unsigned addr_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   instr_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            operation,
  input  logic                  fmt,
  input  logic [3:0]            src_a,
  input  logic [3:0]            src_b,
  input  logic [3:0]            src_c,
  input  logic [3:0]            dest,
  input  logic                  src_a_reg,
  input  logic                  src_b_reg,
  input  logic                  src_c_reg,
  input  logic                  saturate,
  input  logic                  no_shift,
  input  logic [4:0]            instr_shift,
  input  logic [7:0]            res_addr,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [addr_width-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q;
  logic [addr_width:0]   count_q;
  logic [addr_width:0]   accepted_q;
  logic [addr_width:0]   written_q;
  logic                  mem_we_q;
  logic [addr_width-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  err_q;
  logic                  done_q;

  logic [31:0]         word;
  logic                illegal;
  logic                accept;
  logic                write_done;
  logic                last_write;
  logic [addr_width:0] written_inc;

  always_comb begin
    word        = '0;
    word[4:0]   = operation;
    word[5]     = fmt;
    word[10:6]  = {src_a_reg, src_a};
    word[15:11] = {src_b_reg, src_b};
    word[31]    = no_shift;
    if (!fmt) begin
      word[20:16] = {src_c_reg, src_c};
      word[24:21] = dest;
      word[29:25] = instr_shift;
      word[30]    = ~saturate;
    end else begin
      word[19:16] = dest;
      word[27:20] = res_addr;
    end
  end

  // Resource format has no slot for these fields, so any non-default value is flagged.
  assign illegal = fmt && ((src_c != 4'd0) || src_c_reg || (instr_shift != 5'd0) || !saturate);

  assign write_done  = mem_we_q & mem_ready;
  assign written_inc = written_q + 1'b1;
  assign last_write  = write_done && (written_inc == count_q);
  assign in_ready    = (state_q == StRun) && (accepted_q < count_q) && (!mem_we_q || mem_ready);
  assign accept      = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      accepted_q  <= '0;
      written_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            count_q    <= instr_count;
            mem_addr_q <= base_addr;
            accepted_q <= '0;
            written_q  <= '0;
            err_q      <= 1'b0;
            if (instr_count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (write_done) begin
            mem_addr_q <= mem_addr_q + 1'b1;
            written_q  <= written_inc;
          end
          // A new accept reloads the output register in the same cycle the old word leaves.
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= word;
            accepted_q  <= accepted_q + 1'b1;
            err_q       <= err_q | illegal;
          end else if (write_done) begin
            mem_we_q <= 1'b0;
          end
          if (last_write) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues expected writes, a negedge
// monitor pops and compares every completed memory write.
module tb_instr_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   instr_count;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    operation;
  logic          fmt;
  logic [3:0]    src_a, src_b, src_c, dest;
  logic          src_a_reg, src_b_reg, src_c_reg;
  logic          saturate, no_shift;
  logic [4:0]    instr_shift;
  logic [7:0]    res_addr;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, err;

  instr_encoder #(.addr_width(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .instr_count (instr_count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .fmt         (fmt),
    .src_a       (src_a),
    .src_b       (src_b),
    .src_c       (src_c),
    .dest        (dest),
    .src_a_reg   (src_a_reg),
    .src_b_reg   (src_b_reg),
    .src_c_reg   (src_c_reg),
    .saturate    (saturate),
    .no_shift    (no_shift),
    .instr_shift (instr_shift),
    .res_addr    (res_addr),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb_q[$];
  int   wr_log[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: every write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        check("we_only_busy", {31'd0, busy}, 32'd1);
        if (sb_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          check("wr_addr", {24'd0, mem_addr}, {24'd0, sb_q[0].addr});
          check("wr_data", mem_wdata, sb_q[0].data);
          if (mem_ready) begin
            void'(sb_q.pop_front());
            n_writes++;
            wr_log.push_back(cyc);
          end else begin
            check("in_ready_stall", {31'd0, in_ready}, 32'd0);
          end
        end
      end
      if (in_ready) check("ready_only_busy", {31'd0, busy}, 32'd1);
      if (done) n_done++;
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
    base_addr   = base;
    instr_count = cnt;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic f,
                      input logic ar, input logic [3:0] a, input logic br, input logic [3:0] b,
                      input logic cr, input logic [3:0] c, input logic [3:0] d,
                      input logic sat, input logic nsh, input logic [4:0] sh,
                      input logic [7:0] res, input logic [AW-1:0] ea, input logic [31:0] ed);
    int k;
    exp_t e;
    e.addr = ea;
    e.data = ed;
    sb_q.push_back(e);
    operation = op;  fmt = f;
    src_a_reg = ar;  src_a = a;  src_b_reg = br;  src_b = b;
    src_c_reg = cr;  src_c = c;  dest = d;
    saturate = sat;  no_shift = nsh;  instr_shift = sh;  res_addr = res;
    in_valid = 1'b1;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k == 30) fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k == 40) fail_now(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, idx;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; instr_count = '0; in_valid = 1'b0;
    operation = '0; fmt = 1'b0; src_a = '0; src_b = '0; src_c = '0; dest = '0;
    src_a_reg = 1'b0; src_b_reg = 1'b0; src_c_reg = 1'b0; saturate = 1'b1; no_shift = 1'b0;
    instr_shift = '0; res_addr = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three-operand word; res_addr must not leak into the word.
    do_start(8'h10, 9'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(5'd3, 1'b0, 1'b0, 4'd3, 1'b0, 4'd1, 1'b1, 4'd5, 4'd7, 1'b1, 1'b0, 5'd4, 8'hFF,
         8'h10, 32'h08F508C3);
    check("t1_latency_we", {31'd0, mem_we}, 32'd1);
    check("t1_latency_addr", {24'd0, mem_addr}, 32'h10);
    wait_done("t1_done_timeout");
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // Resource format, legal fields.
    do_start(8'h20, 9'd1);
    send(5'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 5'd0, 8'hA5,
         8'h20, 32'h8A590022);
    wait_done("t2_done_timeout");
    check("t2_err", {31'd0, err}, 32'd0);

    // Resource format with stray shift: same word, err set, cleared by next start.
    do_start(8'h30, 9'd1);
    send(5'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 5'd3, 8'hA5,
         8'h30, 32'h8A590022);
    wait_done("t3_done_timeout");
    check("t3_err_set", {31'd0, err}, 32'd1);
    w0 = n_writes;
    do_start(8'h31, 9'd0);
    check("t3_err_cleared", {31'd0, err}, 32'd0);
    wait_done("t3_zero_done_timeout");
    check("t3_zero_no_write", n_writes, w0);

    // Back-to-back stream across the address wrap.
    mem_ready = 1'b1;
    idx = wr_log.size();
    do_start(8'hFE, 9'd4);
    send(5'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 5'd0, 8'h00,
         8'hFE, 32'h00200001);
    send(5'd2, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 5'd0, 8'h00,
         8'hFF, 32'h00400002);
    send(5'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 5'd0, 8'h00,
         8'h00, 32'h00600003);
    send(5'd4, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 1'b1, 1'b0, 5'd0, 8'h00,
         8'h01, 32'h00800004);
    wait_done("t4_done_timeout");
    check("t4_write_count", wr_log.size() - idx, 32'd4);
    if (wr_log.size() - idx == 4) check("t4_no_bubble", wr_log[idx+3] - wr_log[idx], 32'd3);

    // Stall on the second write; a start pulse mid-run must be ignored.
    w0 = n_writes;
    do_start(8'h40, 9'd3);
    send(5'd5, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 5'd0, 8'h00,
         8'h40, 32'h00000505);
    send(5'd6, 1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 5'd0, 8'h00,
         8'h41, 32'hC000F806);
    mem_ready = 1'b0;
    fork
      send(5'd7, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 5'd31, 8'h00,
           8'h42, 32'h3E000007);
      begin
        repeat (5) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
      begin
        @(posedge clk); #1;
        base_addr = 8'h55; instr_count = 9'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done("t5_done_timeout");
    check("t5_write_count", n_writes - w0, 32'd3);
    check("t5_sb_empty", sb_q.size(), 32'd0);

    // Reset mid-load with a pending write, then an empty load.
    mem_ready = 1'b0;
    w0 = n_writes;
    do_start(8'h60, 9'd3);
    send(5'd8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0, 8'h00,
         8'h60, 32'h00000028);
    check("t6_pending_we", {31'd0, mem_we}, 32'd1);
    check("t6_err_set", {31'd0, err}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("t6_rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("t6_rst_mem_wdata", mem_wdata, 32'd0);
    sb_q.delete();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    d0 = n_done;
    do_start(8'h00, 9'd0);
    wait_done("t6_done_timeout");
    check("t6_done_once", n_done - d0, 32'd1);
    check("t6_no_write", n_writes, w0);
    check("t6_addr_after", {24'd0, mem_addr}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("total_done_pulses", n_done, 32'd7);
    check("total_writes", n_writes, 32'd10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
